// File: rtl/digit_scan_decoder_pkg.sv
// Shared constants for the digit scan decoder: mode encoding and default widths.
package digit_scan_decoder_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  localparam int unsigned DEF_SEL_W = 3;
  localparam int unsigned DEF_DIV_W = 16;

endpackage

// File: rtl/digit_scan_decoder_scan_prescaler.sv
// Scan-step prescaler: counts 0..div while running and pulses tick on the
// terminal count. Held at zero whenever not running.
module scan_prescaler
  import digit_scan_decoder_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // Terminal compare uses >= so lowering div below the running count
  // wraps at once instead of waiting for the counter to overflow.
  assign tick = run && (cnt >= div);

  // Count register: clears on reset, when idle, and after each tick.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/digit_scan_decoder.sv
// Digit select decoder with direct decode and masked auto-scan. The
// next-enabled-index search and the one-hot decode are combinational; idx,
// data_out and frame_done are all registered on the same edge.
module digit_scan_decoder
  import digit_scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = DEF_SEL_W,
  parameter int unsigned DIV_W      = DEF_DIV_W,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      data_in,
  input  logic [2**SEL_W-1:0]   mask,
  input  logic [DIV_W-1:0]      div,
  output logic [2**SEL_W-1:0]   data_out,
  output logic [SEL_W-1:0]      idx,
  output logic                  frame_done
);

  localparam int unsigned N = 2**SEL_W;
  localparam logic [N-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;

  mode_e            mode_sel;
  logic             run;
  logic             tick;
  logic             any_enabled;
  logic [SEL_W-1:0] scan_next;
  logic [SEL_W-1:0] idx_nxt;
  logic             frame_nxt;
  logic [N-1:0]     onehot;
  logic [N-1:0]     out_nxt;
  logic             active;

  assign mode_sel    = mode_e'(mode);
  assign run         = ena && (mode_sel == MODE_SCAN);
  assign any_enabled = |mask;

  scan_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .div  (div),
    .tick (tick)
  );

  // Circular search starting just above idx. Walking the offsets from
  // largest to smallest lets the nearest enabled index win; offset N lands
  // on idx itself, which covers the single-enabled-bit wrap.
  always_comb begin
    logic [SEL_W-1:0] cand;
    scan_next = idx;
    cand      = idx;
    for (int unsigned k = N; k >= 1; k--) begin
      cand = idx + SEL_W'(k);
      if (mask[cand]) begin
        scan_next = cand;
      end
    end
  end

  // Next index and wrap detection for direct, scan and frozen cases.
  always_comb begin
    idx_nxt   = idx;
    frame_nxt = 1'b0;
    if (ena) begin
      if (mode_sel == MODE_DIRECT) begin
        idx_nxt = data_in;
      end else if (tick && any_enabled) begin
        idx_nxt   = scan_next;
        frame_nxt = (scan_next <= idx);
      end
    end
  end

  // Decode the new index, blanking when disabled or the slot is masked off.
  always_comb begin
    onehot          = '0;
    onehot[idx_nxt] = 1'b1;
    active          = ena && ((mode_sel == MODE_DIRECT) || mask[idx_nxt]);
    if (!active) begin
      out_nxt = INACTIVE;
    end else if (ACTIVE_LOW) begin
      out_nxt = ~onehot;
    end else begin
      out_nxt = onehot;
    end
  end

  // Output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx        <= '0;
      data_out   <= INACTIVE;
      frame_done <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      data_out   <= out_nxt;
      frame_done <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_digit_scan_decoder.sv
// Self-checking bench for digit_scan_decoder (SEL_W=3, ACTIVE_LOW=1).
module tb_digit_scan_decoder;

  logic        clk;
  logic        rst;
  logic        ena;
  logic        mode;
  logic [2:0]  data_in;
  logic [7:0]  mask;
  logic [15:0] div;
  logic [7:0]  data_out;
  logic [2:0]  idx;
  logic        frame_done;

  int checks;
  int failures;

  // Reference model state
  int         m_idx;
  int         m_cnt;
  logic [7:0] m_out;
  logic       m_frame;

  digit_scan_decoder #(
    .SEL_W      (3),
    .DIV_W      (16),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .mode       (mode),
    .data_in    (data_in),
    .mask       (mask),
    .div        (div),
    .data_out   (data_out),
    .idx        (idx),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lowest enabled index above cur, else lowest enabled overall.
  function automatic int next_enabled(int cur, logic [7:0] m);
    for (int j = cur + 1; j < 8; j++) if (m[j]) return j;
    for (int j = 0; j < 8; j++) if (m[j]) return j;
    return cur;
  endfunction

  // Advance one clock edge and update the model from the inputs seen there;
  // returns #1 after the edge so outputs can be sampled.
  task automatic step();
    bit tick;
    int old;
    @(posedge clk);
    if (rst) begin
      m_idx = 0; m_cnt = 0; m_frame = 1'b0; m_out = 8'hFF;
    end else begin
      m_frame = 1'b0;
      tick = ena && mode && (m_cnt == int'(div));
      if (ena && mode) m_cnt = tick ? 0 : m_cnt + 1;
      else m_cnt = 0;
      if (ena) begin
        if (!mode) m_idx = int'(data_in);
        else if (tick && mask != 8'h00) begin
          old = m_idx;
          m_idx = next_enabled(old, mask);
          m_frame = (m_idx <= old);
        end
      end
      if (!ena || (mode && !mask[m_idx])) m_out = 8'hFF;
      else m_out = ~(8'h01 << m_idx);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; mode = 1'b1; data_in = 3'd6; mask = 8'hFF; div = 16'd0;
    step(); step();
    checks++;
    if (data_out !== 8'hFF) begin failures++; $display("FAIL reset_data_out got=%h exp=%h", data_out, 8'hFF); end
    checks++;
    if (idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    mode = 1'b0; ena = 1'b1; data_in = 3'd5;
    step();
    checks++;
    if (data_out !== 8'hDF || idx !== 3'd5) begin
      failures++; $display("FAIL direct_5 got=%h/%0d exp=DF/5", data_out, idx);
    end
    ena = 1'b0; data_in = 3'd2;
    step();
    checks++;
    if (data_out !== 8'hFF || idx !== 3'd5) begin
      failures++; $display("FAIL direct_ena0 got=%h/%0d exp=FF/5", data_out, idx);
    end
    ena = 1'b1;
    for (int i = 0; i < 16; i++) begin
      data_in = 3'($urandom_range(0, 7));
      step();
      checks++;
      if (data_out !== m_out || idx !== 3'(m_idx) || frame_done !== 1'b0) begin
        failures++; $display("FAIL direct_rand got=%h/%0d/%b exp=%h/%0d/0", data_out, idx, frame_done, m_out, m_idx);
      end
    end
  endtask

  task automatic test_scan_full();
    logic [7:0] seen[$];
    logic [7:0] exp_seq[9] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
    int frames;
    rst = 1'b1; step(); rst = 1'b0;
    ena = 1'b1; mode = 1'b1; mask = 8'hFF; div = 16'd2;
    frames = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (seen.size() == 0 || seen[seen.size()-1] != data_out) seen.push_back(data_out);
      if (frame_done) frames++;
      checks++;
      if (data_out !== m_out || idx !== 3'(m_idx) || frame_done !== m_frame) begin
        failures++; $display("FAIL scan_full_cyc%0d got=%h/%0d/%b exp=%h/%0d/%b", i, data_out, idx, frame_done, m_out, m_idx, m_frame);
      end
    end
    checks++;
    if (seen.size() != 9) begin
      failures++; $display("FAIL scan_full_seq_len got=%0d exp=9", seen.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (seen[i] !== exp_seq[i]) begin failures++; $display("FAIL scan_full_seq%0d got=%h exp=%h", i, seen[i], exp_seq[i]); end
      end
    end
    checks++;
    if (frames != 1) begin failures++; $display("FAIL scan_full_frames got=%0d exp=1", frames); end
  endtask

  task automatic test_skip();
    int exp_idx[9] = '{2, 5, 0, 2, 5, 0, 2, 5, 0};
    rst = 1'b1; step(); rst = 1'b0;
    ena = 1'b1; mode = 1'b1; mask = 8'b0010_0101; div = 16'd0;
    for (int i = 0; i < 9; i++) begin
      step();
      checks++;
      if (idx !== 3'(exp_idx[i]) || frame_done !== (exp_idx[i] == 0)) begin
        failures++; $display("FAIL skip_cyc%0d got=%0d/%b exp=%0d/%b", i, idx, frame_done, exp_idx[i], exp_idx[i] == 0);
      end
      checks++;
      if (data_out !== m_out) begin failures++; $display("FAIL skip_out%0d got=%h exp=%h", i, data_out, m_out); end
    end
  endtask

  task automatic test_mask_zero();
    logic [2:0] held;
    bit bad;
    mask = 8'h00; div = 16'd0; ena = 1'b1; mode = 1'b1;
    step();
    held = idx;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_out !== 8'hFF || idx !== held || frame_done !== 1'b0 || idx !== 3'(m_idx)) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL mask_zero got=%h/%0d/%b exp=FF/%0d/0", data_out, idx, frame_done, held); end
  endtask

  task automatic test_reset_mid_scan();
    int budget;
    rst = 1'b1; step(); rst = 1'b0;
    ena = 1'b1; mode = 1'b1; mask = 8'hFF; div = 16'd1;
    budget = 0;
    while (idx !== 3'd4 && budget < 100) begin step(); budget++; end
    checks++;
    if (budget >= 100) begin failures++; $display("FAIL reach_idx4 got=%0d exp=4 (timeout)", idx); end
    rst = 1'b1;
    step();
    checks++;
    if (idx !== 3'd0 || data_out !== 8'hFF || frame_done !== 1'b0) begin
      failures++; $display("FAIL rst_mid got=%h/%0d/%b exp=FF/0/0", data_out, idx, frame_done);
    end
    rst = 1'b0;
    step();
    checks++;
    if (idx !== 3'd0 || data_out !== 8'hFE) begin
      failures++; $display("FAIL rst_restart1 got=%h/%0d exp=FE/0", data_out, idx);
    end
    step();
    checks++;
    if (idx !== 3'd1 || data_out !== 8'hFD) begin
      failures++; $display("FAIL rst_restart2 got=%h/%0d exp=FD/1", data_out, idx);
    end
  endtask

  task automatic test_mask_clear();
    rst = 1'b1; step(); rst = 1'b0;
    ena = 1'b1; mode = 1'b1; mask = 8'hFF; div = 16'd3;
    step();
    mask = 8'hFE;
    step();
    checks++;
    if (data_out !== 8'hFF || idx !== 3'd0) begin
      failures++; $display("FAIL mask_clear_blank got=%h/%0d exp=FF/0", data_out, idx);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (data_out !== m_out || idx !== 3'(m_idx) || frame_done !== m_frame) begin
        failures++; $display("FAIL mask_clear_cyc%0d got=%h/%0d/%b exp=%h/%0d/%b", i, data_out, idx, frame_done, m_out, m_idx, m_frame);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 99) < 2);
      ena     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      data_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) mask = 8'($urandom);
      // div only changes while the prescaler is being held clear
      if (!mode && $urandom_range(0, 3) == 0) div = 16'($urandom_range(0, 3));
      step();
      checks++;
      if (data_out !== m_out || idx !== 3'(m_idx) || frame_done !== m_frame) begin
        failures++; $display("FAIL random_cyc%0d got=%h/%0d/%b exp=%h/%0d/%b", i, data_out, idx, frame_done, m_out, m_idx, m_frame);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_idx = 0; m_cnt = 0; m_out = 8'hFF; m_frame = 1'b0;
    rst = 1'b1; ena = 1'b0; mode = 1'b0; data_in = '0; mask = '0; div = '0;
    test_reset();
    test_direct();
    test_scan_full();
    test_skip();
    test_mask_zero();
    test_reset_mid_scan();
    test_mask_clear();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
